calc_operand_sequencer: RTL and testbench
=========================================

// Module: calc_operand_sequencer
// PURPOSE
//  Sequential front end for the 4-bit combinational calculator: collects operand A, operator and
//  operand B from switch/button inputs one at a time, drives the calculator's A/B/operator inputs
//  from registers, and captures its result one cycle later into a held display register.
//  Sits between board I/O (switches, enter/clear buttons) and the calculator core.
// PARAMETERS
//  WIDTH     4  operand/result width; must match the calculator core.
//  CHAIN_EN  1  1: enter in S_RESULT reuses the result as the new A (goes to S_OP);
//               0: enter in S_RESULT returns to S_A.
// PORTS
//  i_clk            in   1      system clock, all logic on rising edge
//  i_reset_n        in   1      synchronous reset, active-low
//  i_digit          in   WIDTH  operand value from switches, sampled on accepted enter
//  i_op             in   2      operator select: 00 add, 01 sub, 10 mul, 11 div
//  i_enter          in   1      enter button level, already debounced; rising edge is the event
//  i_clear          in   1      clear level; highest priority after reset
//  o_A              out  WIDTH  registered operand A to calculator
//  o_B              out  WIDTH  registered operand B to calculator
//  o_selOperator    out  2      registered operator to calculator
//  i_result         in   WIDTH  combinational result returned by calculator
//  o_display        out  WIDTH  value to show on the display
//  o_state          out  3      current FSM state encoding (below)
//  o_result_valid   out  1      high while in S_RESULT
//  o_div_by_zero    out  1      high in S_RESULT when last op was div with B == 0
// BEHAVIOUR
//  - Reset (i_reset_n==0 at clk edge): state=S_A; o_A,o_B,o_display=0; o_selOperator=00;
//    o_result_valid=0; o_div_by_zero=0; enter edge-detect register=0.
//  - Enter event: i_enter==1 this cycle and registered previous i_enter==0. A held button = 1 event.
//  - Edge-detect register updates every cycle, including during clear.
//  - States: S_A=000, S_OP=001, S_B=010, S_EXEC=011, S_RESULT=100.
//  - S_A: enter -> o_A<=i_digit, go S_OP.
//  - S_OP: enter -> o_selOperator<=i_op, go S_B.
//  - S_B: enter -> o_B<=i_digit, go S_EXEC.
//  - S_EXEC: one cycle; captures i_result into the result register; unconditionally -> S_RESULT.
//    o_div_by_zero<=(o_selOperator==11 && o_B==0). Enter events in S_EXEC are ignored.
//  - S_RESULT: enter -> CHAIN_EN ? (o_A<=result, go S_OP) : go S_A. Flags clear on leaving.
//  - Latency: result visible on o_display / o_result_valid 2 cycles after the enter edge that
//    latches B.
//  - o_display (registered): S_A and S_B show i_digit delayed 1 cycle; S_OP shows o_A;
//    S_EXEC holds its previous value; S_RESULT shows the result register.
//  - Arithmetic: no widening; the result is the calculator's WIDTH-bit output (mod 2^WIDTH).
//  - Div by zero: the core returns 0; the result register stores 0 and o_div_by_zero=1.
//  - i_clear==1 at a clock edge (any state, incl. mid-operation): same values as reset except the
//    edge-detect register. Clear overrides a simultaneous enter.
//  - Unused state encodings (101-111) -> S_A with reset values.
// TESTING
//  1 Reset: hold i_reset_n=0 3 cycles -> state 000, all outputs 0; release with enter low.
//  2 Add: A=3, op=00, B=5 (one enter pulse each) -> S_RESULT 2 cycles after B enter,
//    o_display=8, o_result_valid=1.
//  3 Wrap: 3-5 -> o_display=4'hE; 6*3 -> o_display=4'h2; no flags set.
//  4 Div: 7/0 -> o_display=0, o_div_by_zero=1; 9/2 -> o_display=4, o_div_by_zero=0.
//  5 Chain (CHAIN_EN=1): after 3+5=8, enter -> S_OP with o_A=8; op=00, B=9 -> o_display=1.
//  6 Held enter for 10 cycles in S_A -> exactly one advance, to S_OP. Clear asserted in S_B
//    together with enter -> next state S_A, o_A=o_B=0.

Source files
------------

// File: rtl/calc_operand_sequencer.sv
// Sequential front end for the 4-bit calculator core: collects A, operator and B on enter
// events, drives the core from registers and holds the captured result for the display.
module calc_operand_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          CHAIN_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_digit,
  input  logic [1:0]       i_op,
  input  logic             i_enter,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_A,
  output logic [WIDTH-1:0] o_B,
  output logic [1:0]       o_selOperator,
  input  logic [WIDTH-1:0] i_result,
  output logic [WIDTH-1:0] o_display,
  output logic [2:0]       o_state,
  output logic             o_result_valid,
  output logic             o_div_by_zero
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 2;
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(2'b11);

  typedef enum logic [STATE_W-1:0] {
    S_A      = 3'b000,
    S_OP     = 3'b001,
    S_B      = 3'b010,
    S_EXEC   = 3'b011,
    S_RESULT = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic             enter_q;
  logic             enter_evt;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] a_d, b_d, disp_d;
  logic [OP_W-1:0]  op_d;
  logic             valid_d, dbz_d;

  // One event per press: rising edge of the debounced enter level.
  assign enter_evt = i_enter & ~enter_q;
  assign o_state   = STATE_W'(state_q);

  // Next-state and next-register values; every output register reflects the state being entered.
  always_comb begin
    state_d  = state_q;
    a_d      = o_A;
    b_d      = o_B;
    op_d     = o_selOperator;
    result_d = result_q;
    disp_d   = o_display;
    valid_d  = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      S_A: begin
        disp_d = i_digit;
        if (enter_evt) begin
          a_d     = i_digit;
          state_d = S_OP;
        end
      end
      S_OP: begin
        disp_d = o_A;
        if (enter_evt) begin
          op_d    = i_op;
          disp_d  = i_digit;
          state_d = S_B;
        end
      end
      S_B: begin
        disp_d = i_digit;
        if (enter_evt) begin
          b_d     = i_digit;
          disp_d  = o_display;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = i_result;
        disp_d   = i_result;
        valid_d  = 1'b1;
        dbz_d    = (o_selOperator == OP_DIV) && (o_B == WIDTH'(0));
        state_d  = S_RESULT;
      end
      S_RESULT: begin
        disp_d  = result_q;
        valid_d = 1'b1;
        dbz_d   = o_div_by_zero;
        if (enter_evt) begin
          valid_d = 1'b0;
          dbz_d   = 1'b0;
          if (CHAIN_EN) begin
            a_d     = result_q;
            disp_d  = result_q;
            state_d = S_OP;
          end else begin
            disp_d  = i_digit;
            state_d = S_A;
          end
        end
      end
      default: begin
        state_d  = S_A;
        a_d      = '0;
        b_d      = '0;
        op_d     = '0;
        result_d = '0;
        disp_d   = '0;
      end
    endcase

    // Clear wins over any enter event in the same cycle.
    if (i_clear) begin
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      disp_d   = '0;
      valid_d  = 1'b0;
      dbz_d    = 1'b0;
    end
  end

  // State and datapath registers; the edge detector keeps tracking enter through clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q        <= S_A;
      enter_q        <= 1'b0;
      o_A            <= '0;
      o_B            <= '0;
      o_selOperator  <= '0;
      result_q       <= '0;
      o_display      <= '0;
      o_result_valid <= 1'b0;
      o_div_by_zero  <= 1'b0;
    end else begin
      state_q        <= state_d;
      enter_q        <= i_enter;
      o_A            <= a_d;
      o_B            <= b_d;
      o_selOperator  <= op_d;
      result_q       <= result_d;
      o_display      <= disp_d;
      o_result_valid <= valid_d;
      o_div_by_zero  <= dbz_d;
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench: scripted and random calculator sessions compared against
// arithmetic expectations derived from the operands and operators the bench enters.
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] digit;
  logic [1:0] op;
  logic       enter;
  logic       clear;
  logic [3:0] a_out, b_out, result, display;
  logic [1:0] sel_op;
  logic [2:0] state;
  logic       result_valid, div_by_zero;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  calc_operand_sequencer #(.WIDTH(4), .CHAIN_EN(1'b1)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_digit(digit), .i_op(op), .i_enter(enter),
    .i_clear(clear), .o_A(a_out), .o_B(b_out), .o_selOperator(sel_op), .i_result(result),
    .o_display(display), .o_state(state), .o_result_valid(result_valid),
    .o_div_by_zero(div_by_zero)
  );

  // Calculator arithmetic: WIDTH-bit wrap, divide by zero yields 0.
  function automatic logic [3:0] calc(input logic [3:0] a, input logic [1:0] o, input logic [3:0] b);
    int r;
    case (o)
      2'b00:   r = int'(a) + int'(b);
      2'b01:   r = int'(a) - int'(b);
      2'b10:   r = int'(a) * int'(b);
      default: r = (b == 4'd0) ? 0 : int'(a) / int'(b);
    endcase
    return 4'(r);
  endfunction

  // The combinational calculator core sitting behind the sequencer.
  always_comb result = calc(a_out, sel_op, b_out);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter held high for exactly one sampled edge, then released.
  task automatic press(input logic [3:0] d, input logic [1:0] o);
    digit = d;
    op    = o;
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (state !== 3'd0 || a_out !== 4'd0 || b_out !== 4'd0 || display !== 4'd0)
      $display("FAIL clear: state=%0d A=%0d B=%0d disp=%0d want all 0", state, a_out, b_out, display);
    else passes++;
  endtask

  // Enters A, op, B from S_A and checks the path and the final result view.
  task automatic run_calc(input logic [3:0] a, input logic [1:0] o, input logic [3:0] b);
    logic [3:0] exp;
    logic       exp_dbz;
    exp     = calc(a, o, b);
    exp_dbz = (o == 2'b11) && (b == 4'd0);
    press(a, 2'b00);
    checks++;
    if (state !== 3'd1 || a_out !== a || display !== a)
      $display("FAIL enter_a: state=%0d A=%0d disp=%0d want 1/%0d/%0d", state, a_out, display, a, a);
    else passes++;
    step();
    press(4'd0, o);
    checks++;
    if (state !== 3'd2 || sel_op !== o)
      $display("FAIL enter_op: state=%0d op=%0d want 2/%0d", state, sel_op, o);
    else passes++;
    step();
    press(b, 2'b00);
    checks++;
    if (state !== 3'd3 || b_out !== b || result_valid !== 1'b0)
      $display("FAIL enter_b: state=%0d B=%0d valid=%0d want 3/%0d/0", state, b_out, result_valid, b);
    else passes++;
    step();
    checks++;
    if (state !== 3'd4 || result_valid !== 1'b1 || display !== exp || div_by_zero !== exp_dbz)
      $display("FAIL result %0d op%0d %0d: state=%0d valid=%0d disp=%0h dbz=%0d want 4/1/%0h/%0d",
               a, o, b, state, result_valid, display, div_by_zero, exp, exp_dbz);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    digit = 4'hA; op = 2'b10; enter = 1'b0; clear = 1'b0;
    repeat (3) step();
    checks++;
    if (state !== 3'd0 || a_out !== 4'd0 || b_out !== 4'd0 || sel_op !== 2'd0 ||
        display !== 4'd0 || result_valid !== 1'b0 || div_by_zero !== 1'b0)
      $display("FAIL reset: state=%0d A=%0d B=%0d op=%0d disp=%0d valid=%0d dbz=%0d want all 0",
               state, a_out, b_out, sel_op, display, result_valid, div_by_zero);
    else passes++;
    reset_n = 1'b1;
    digit = 4'd0;
    step();
  endtask

  task automatic test_add();
    run_calc(4'd3, 2'b00, 4'd5);
    checks++;
    if (display !== 4'd8) $display("FAIL add_display: got %0d want 8", display);
    else passes++;
  endtask

  task automatic test_wrap();
    do_clear();
    run_calc(4'd3, 2'b01, 4'd5);
    checks++;
    if (display !== 4'hE || div_by_zero !== 1'b0)
      $display("FAIL sub_wrap: disp=%0h dbz=%0d want e/0", display, div_by_zero);
    else passes++;
    do_clear();
    run_calc(4'd6, 2'b10, 4'd3);
    checks++;
    if (display !== 4'h2 || div_by_zero !== 1'b0)
      $display("FAIL mul_wrap: disp=%0h dbz=%0d want 2/0", display, div_by_zero);
    else passes++;
  endtask

  task automatic test_div();
    do_clear();
    run_calc(4'd7, 2'b11, 4'd0);
    checks++;
    if (display !== 4'd0 || div_by_zero !== 1'b1)
      $display("FAIL div_zero: disp=%0d dbz=%0d want 0/1", display, div_by_zero);
    else passes++;
    do_clear();
    checks++;
    if (div_by_zero !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL dbz_cleared: dbz=%0d valid=%0d want 0/0", div_by_zero, result_valid);
    else passes++;
    run_calc(4'd9, 2'b11, 4'd2);
    checks++;
    if (display !== 4'd4 || div_by_zero !== 1'b0)
      $display("FAIL div: disp=%0d dbz=%0d want 4/0", display, div_by_zero);
    else passes++;
  endtask

  // From S_RESULT, enter reuses the result as A; continues with op2/b2.
  task automatic chain(input logic [3:0] prev, input logic [1:0] o2, input logic [3:0] b2);
    logic [3:0] exp;
    exp = calc(prev, o2, b2);
    step();
    press(4'hF, 2'b00);
    checks++;
    if (state !== 3'd1 || a_out !== prev || display !== prev || result_valid !== 1'b0 || div_by_zero !== 1'b0)
      $display("FAIL chain_a: state=%0d A=%0d disp=%0d valid=%0d dbz=%0d want 1/%0d/%0d/0/0",
               state, a_out, display, result_valid, div_by_zero, prev, prev);
    else passes++;
    step();
    press(4'd0, o2);
    step();
    press(b2, 2'b00);
    step();
    checks++;
    if (state !== 3'd4 || display !== exp || result_valid !== 1'b1)
      $display("FAIL chain_result %0d op%0d %0d: state=%0d disp=%0h valid=%0d want 4/%0h/1",
               prev, o2, b2, state, display, result_valid, exp);
    else passes++;
  endtask

  task automatic test_chain();
    do_clear();
    run_calc(4'd3, 2'b00, 4'd5);
    chain(4'd8, 2'b00, 4'd9);
  endtask

  task automatic test_digit_display();
    logic [3:0] d;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      d = 4'($urandom_range(0, 15));
      digit = d;
      step();
      checks++;
      if (display !== d || state !== 3'd0)
        $display("FAIL digit_view: disp=%0d state=%0d want %0d/0", display, state, d);
      else passes++;
    end
  endtask

  task automatic test_held_enter();
    do_clear();
    digit = 4'd6;
    enter = 1'b1;
    repeat (10) step();
    checks++;
    if (state !== 3'd1 || a_out !== 4'd6)
      $display("FAIL held_enter: state=%0d A=%0d want 1/6", state, a_out);
    else passes++;
    enter = 1'b0;
    step();
    press(4'd0, 2'b01);
    step();
    checks++;
    if (state !== 3'd2) $display("FAIL to_b: state=%0d want 2", state);
    else passes++;
    // Clear together with a fresh enter event in S_B.
    digit = 4'd5;
    clear = 1'b1;
    enter = 1'b1;
    step();
    checks++;
    if (state !== 3'd0 || a_out !== 4'd0 || b_out !== 4'd0 || sel_op !== 2'd0)
      $display("FAIL clear_over_enter: state=%0d A=%0d B=%0d op=%0d want 0/0/0/0", state, a_out, b_out, sel_op);
    else passes++;
    clear = 1'b0;
    step();
    checks++;
    if (state !== 3'd0)
      $display("FAIL held_after_clear: state=%0d want 0", state);
    else passes++;
    enter = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [3:0] a, b, b2;
    logic [1:0] o, o2;
    for (int i = 0; i < 20; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      b2 = 4'($urandom_range(0, 15));
      o  = 2'($urandom_range(0, 3));
      o2 = 2'($urandom_range(0, 3));
      if (i % 5 == 0) begin
        o = 2'b11;
        b = 4'd0;
      end
      do_clear();
      run_calc(a, o, b);
      chain(calc(a, o, b), o2, b2);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_div();
    test_chain();
    test_digit_display();
    test_held_enter();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
